// File: rtl/boot_rom_arbiter.sv
// boot_rom_arbiter: shares a synchronous boot ROM between fetch and load requesters with a fixed-latency tag pipeline.
// Define BOOTROM_ARB_RR_EN for round-robin arbitration; the default is fixed priority, ld over if.
module boot_rom_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32,
  parameter int ROM_AW = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_err,
  output logic              rom_ce,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              idle
);
  logic              pick_ld;
  logic              any_gnt;
  logic              in_range;
  logic [ADDR_W-1:0] sel_addr;
  logic [RD_LAT-1:0] tv, town, terr;
  logic              unused;
  // Byte-offset bits carry no information for word-only accesses.
  assign unused = ^{if_addr[1:0], ld_addr[1:0]};
`ifdef BOOTROM_ARB_RR_EN
  logic last_ld;
  always_ff @(posedge clk or posedge rst)
    if (rst) last_ld <= 1'b1;
    else if (any_gnt) last_ld <= ld_gnt;
  assign pick_ld = ld_req && (!if_req || !last_ld);
`else
  assign pick_ld = ld_req;
`endif
  assign ld_gnt   = !rst && pick_ld;
  assign if_gnt   = !rst && if_req && !pick_ld;
  assign any_gnt  = if_gnt || ld_gnt;
  assign sel_addr = pick_ld ? ld_addr : if_addr;
  assign in_range = (sel_addr >> (ROM_AW + 2)) == '0;
  assign rom_ce   = any_gnt && in_range;
  assign rom_addr = rom_ce ? sel_addr[ROM_AW+1:2] : '0;
  // Out-of-range grants still occupy a tag slot so response order and latency stay fixed.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tv   <= '0;
      town <= '0;
      terr <= '0;
    end else begin
      tv[0]   <= any_gnt;
      town[0] <= ld_gnt;
      terr[0] <= any_gnt && !in_range;
      for (int i = 1; i < RD_LAT; i++) begin
        tv[i]   <= tv[i-1];
        town[i] <= town[i-1];
        terr[i] <= terr[i-1];
      end
    end
  assign if_rvalid = tv[RD_LAT-1] && !town[RD_LAT-1];
  assign ld_rvalid = tv[RD_LAT-1] && town[RD_LAT-1];
  assign if_err    = if_rvalid && terr[RD_LAT-1];
  assign ld_err    = ld_rvalid && terr[RD_LAT-1];
  assign if_rdata  = (if_rvalid && !terr[RD_LAT-1]) ? rom_dout : '0;
  assign ld_rdata  = (ld_rvalid && !terr[RD_LAT-1]) ? rom_dout : '0;
  assign idle      = ~|tv;
endmodule

// File: tb/tb_boot_rom_arbiter.sv
// tb_boot_rom_arbiter: directed plus randomized checks of boot_rom_arbiter against a queue-based response model.
module tb_boot_rom_arbiter;
  localparam int RD_LAT = 2;
  logic        clk = 0, rst = 1;
  logic        if_req = 0, ld_req = 0;
  logic [63:0] if_addr = 0, ld_addr = 0;
  logic        if_gnt, if_rvalid, if_err, ld_gnt, ld_rvalid, ld_err, rom_ce, idle;
  logic [31:0] if_rdata, ld_rdata, rom_dout;
  logic [7:0]  rom_addr;
  int          vectors = 0, errors = 0, cyc = 0;
  bit          last_if = 0;
  typedef struct {int due; bit own_ld; bit err; logic [31:0] data;} resp_t;
  resp_t       q[$];
  logic [31:0] mem [256];
  logic [31:0] rpipe [RD_LAT];

  boot_rom_arbiter #(.ADDR_W(64), .DATA_W(32), .ROM_AW(8), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_err(ld_err),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_dout(rom_dout), .idle(idle)
  );

  always #5 clk = ~clk;

  // Synchronous ROM with RD_LAT-cycle latency; junk data when not enabled.
  always @(posedge clk) begin
    rpipe[0] <= rom_ce ? mem[rom_addr] : 32'hdead_beef;
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign rom_dout = rpipe[RD_LAT-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] rnd_addr();
    if ($urandom_range(0, 9) == 0) return {$urandom, $urandom} | 64'h400;
    return 64'($urandom_range(0, 1023));
  endfunction

  task automatic cycle(input logic ir, input logic [63:0] ia, input logic lr, input logic [63:0] la,
                       output bit gi, output bit gl);
    logic [63:0] a;
    bit ok, hv;
    resp_t r;
    @(posedge clk); #1;
    if_req = ir; if_addr = ia; ld_req = lr; ld_addr = la;
    @(negedge clk);
`ifdef BOOTROM_ARB_RR_EN
    gl = lr && (!ir || last_if);
`else
    gl = lr;
`endif
    gi = ir && !gl;
    a  = gl ? la : ia;
    ok = a < 64'h400;
    check("if_gnt", 64'(if_gnt), 64'(gi));
    check("ld_gnt", 64'(ld_gnt), 64'(gl));
    check("rom_ce", 64'(rom_ce), 64'((gi || gl) && ok));
    check("rom_addr", 64'(rom_addr), ((gi || gl) && ok) ? a / 4 : 64'd0);
    check("idle", 64'(idle), 64'(q.size() == 0));
    hv = q.size() > 0 && q[0].due == cyc;
    r = '{due: 0, own_ld: 0, err: 0, data: 0};
    if (hv) r = q.pop_front();
    check("if_rvalid", 64'(if_rvalid), 64'(hv && !r.own_ld));
    check("if_err", 64'(if_err), 64'(hv && !r.own_ld && r.err));
    check("if_rdata", 64'(if_rdata), (hv && !r.own_ld) ? 64'(r.data) : 64'd0);
    check("ld_rvalid", 64'(ld_rvalid), 64'(hv && r.own_ld));
    check("ld_err", 64'(ld_err), 64'(hv && r.own_ld && r.err));
    check("ld_rdata", 64'(ld_rdata), (hv && r.own_ld) ? 64'(r.data) : 64'd0);
    if (gi || gl) begin
      q.push_back('{due: cyc + RD_LAT, own_ld: gl, err: !ok, data: ok ? mem[a[9:2]] : 32'd0});
      last_if = gi;
    end
    cyc++;
  endtask

  task automatic idles(input int n);
    bit gi, gl;
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, gi, gl);
  endtask

  task automatic check_reset_outputs();
    check("rst_if_gnt", 64'(if_gnt), 0);
    check("rst_ld_gnt", 64'(ld_gnt), 0);
    check("rst_rom_ce", 64'(rom_ce), 0);
    check("rst_rvalid", 64'({if_rvalid, ld_rvalid}), 0);
    check("rst_rdata", 64'({if_rdata, ld_rdata}), 0);
    check("rst_err", 64'({if_err, ld_err}), 0);
    check("rst_idle", 64'(idle), 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    if_req = 1; if_addr = 0; ld_req = 1; ld_addr = 4; rst = 1;
    #1 check_reset_outputs();
    @(posedge clk); #1;
    check_reset_outputs();
    rst = 0; if_req = 0; ld_req = 0;
    q.delete();
    last_if = 0;
  endtask

  initial begin
    bit gi, gl, ir, lr;
    logic [63:0] ia, la;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    #1 check_reset_outputs();
    @(posedge clk); @(posedge clk); #1 rst = 0;
    idles(4);
    cycle(1, 64'h10, 0, 0, gi, gl);
    idles(3);
    for (int i = 0; i < 4; i++) cycle(1, 64'h0, 1, 64'h4, gi, gl);
    idles(3);
    cycle(0, 0, 1, 64'h400, gi, gl);
    idles(3);
    cycle(1, 64'h0, 0, 0, gi, gl);
    cycle(1, 64'h4, 0, 0, gi, gl);
    cycle(1, 64'h8, 0, 0, gi, gl);
    idles(4);
    cycle(1, 64'h10, 0, 0, gi, gl);
    do_reset();
    idles(RD_LAT + 2);
    cycle(1, 64'h8, 0, 0, gi, gl);
    idles(3);
    cycle(1, 64'h3fc, 1, 64'h3ff, gi, gl);
    cycle(1, 64'h3fc, 1, 64'h8000_0000_0000_0000, gi, gl);
    idles(3);
    ir = 0; lr = 0; ia = 0; la = 0; gi = 0; gl = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!ir || gi) begin ir = $urandom_range(0, 2) != 0; ia = rnd_addr(); end
      if (!lr || gl) begin lr = $urandom_range(0, 2) != 0; la = rnd_addr(); end
      cycle(ir, ia, lr, la, gi, gl);
      if (n == 1500) begin
        do_reset();
        ir = 0; lr = 0; gi = 0; gl = 0;
      end
    end
    idles(RD_LAT + 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
